// File: rtl/uart_bridge_pkg.sv
// uart_bridge_pkg: shared FSM state type and protocol byte constants for the UART register bridge
package uart_bridge_pkg;
    typedef enum logic [2:0] {IDLE, CMD, ADDR, DATA, CHK, EXEC, RD_WAIT, RESP} state_t;
    localparam logic [7:0] CMD_WR  = 8'h01;
    localparam logic [7:0] CMD_RD  = 8'h02;
    localparam logic [7:0] RSP_ACK = 8'h06;
    localparam logic [7:0] RSP_NAK = 8'h15;
endpackage

// File: rtl/uart_bridge_timer.sv
// uart_bridge_timer: inter-byte timeout counter with clear, enable and expire
// Ports: clk, reset (sync, active-high), i_clr (restart count), i_en (count this cycle),
//        o_expire (high in the cycle the count steps to TIMEOUT_CYCLES-1)
module uart_bridge_timer #(
    parameter int TIMEOUT_CYCLES = 100000,
    parameter int TO_W           = 17
) (
    input  logic clk,
    input  logic reset,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expire
);
    logic [TO_W-1:0] r_cnt;
    always_ff @(posedge clk) begin
        if (reset || i_clr) r_cnt <= '0;
        else if (i_en) r_cnt <= r_cnt + TO_W'(1);
    end
    // Fires while incrementing from TIMEOUT_CYCLES-2, i.e. TIMEOUT_CYCLES-1 idle cycles after the last pop
    assign o_expire = i_en && r_cnt == TO_W'(TIMEOUT_CYCLES - 2);
endmodule

// File: rtl/uart_reg_bridge.sv
// uart_reg_bridge: parses framed read/write requests from the UART RX FIFO, runs them on a register bus, answers via TX FIFO
// Ports: clk, reset (sync, active-high); RX FIFO r_data/rx_empty/rd_uart; TX FIFO w_data/wr_uart/tx_full;
//        register bus reg_addr/reg_wdata/reg_wr_en/reg_rd_en/reg_rdata; status busy/frame_err/timeout_err
// Optional: UART_BRIDGE_TIMEOUT_EN adds the inter-byte timeout (uart_bridge_timer); otherwise timeout_err is 0
module uart_reg_bridge
    import uart_bridge_pkg::*;
#(
    parameter logic [7:0] SYNC_BYTE      = 8'hA5,
    parameter int         TIMEOUT_CYCLES = 100000,
    parameter int         TO_W           = 17
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] r_data,
    input  logic       rx_empty,
    output logic       rd_uart,
    output logic [7:0] w_data,
    output logic       wr_uart,
    input  logic       tx_full,
    output logic [7:0] reg_addr,
    output logic [7:0] reg_wdata,
    output logic       reg_wr_en,
    output logic       reg_rd_en,
    input  logic [7:0] reg_rdata,
    output logic       busy,
    output logic       frame_err,
    output logic       timeout_err
);
    state_t     r_state, w_next;
    logic [7:0] r_cmd, r_rdata, r_rsp0;
    logic [1:0] r_idx, r_last;
    logic       w_pop, w_cmd_ok, w_chk_ok, w_to;

    // Outputs are gated by reset so a partial frame is never popped or answered in the reset cycle
    assign w_pop     = !reset && !rx_empty && r_state inside {IDLE, CMD, ADDR, DATA, CHK};
    assign w_cmd_ok  = r_data == CMD_WR || r_data == CMD_RD;
    assign w_chk_ok  = r_data == (r_cmd ^ reg_addr ^ (r_cmd == CMD_WR ? reg_wdata : 8'h00));
    assign rd_uart   = w_pop;
    assign reg_wr_en = !reset && r_state == EXEC && r_cmd == CMD_WR;
    assign reg_rd_en = !reset && r_state == EXEC && r_cmd == CMD_RD;
    assign wr_uart   = !reset && r_state == RESP && !tx_full;
    assign w_data    = r_state == RESP ? (r_idx == 2'd0 ? r_rsp0 : r_rdata) : 8'h00;
    assign busy      = r_state != IDLE;
    assign frame_err = w_pop && ((r_state == CMD && !w_cmd_ok) || (r_state == CHK && !w_chk_ok));

`ifdef UART_BRIDGE_TIMEOUT_EN
    logic w_expire;
    uart_bridge_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES), .TO_W(TO_W)) u_timer (
        .clk     (clk),
        .reset   (reset),
        .i_clr   (w_pop),
        .i_en    (rx_empty && r_state inside {CMD, ADDR, DATA, CHK}),
        .o_expire(w_expire)
    );
    assign w_to = !reset && w_expire;
`else
    logic w_unused_to_cfg;
    assign w_unused_to_cfg = ^{TIMEOUT_CYCLES, TO_W};
    assign w_to = 1'b0;
`endif
    assign timeout_err = w_to;

    always_ff @(posedge clk) begin
        r_state <= reset ? IDLE : w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = (w_pop && r_data == SYNC_BYTE) ? CMD : IDLE;
            CMD:     w_next = w_pop ? (w_cmd_ok ? ADDR : RESP) : CMD;
            ADDR:    w_next = w_pop ? (r_cmd == CMD_WR ? DATA : CHK) : ADDR;
            DATA:    w_next = w_pop ? CHK : DATA;
            CHK:     w_next = w_pop ? (w_chk_ok ? EXEC : RESP) : CHK;
            EXEC:    w_next = r_cmd == CMD_WR ? RESP : RD_WAIT;
            RD_WAIT: w_next = RESP;
            RESP:    w_next = (wr_uart && r_idx == r_last) ? IDLE : RESP;
            default: w_next = IDLE;
        endcase
        if (w_to) w_next = IDLE;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cmd     <= '0;
            reg_addr  <= '0;
            reg_wdata <= '0;
            r_rdata   <= '0;
            r_rsp0    <= '0;
            r_idx     <= '0;
            r_last    <= '0;
        end else begin
            if (w_pop && r_state == CMD) r_cmd <= r_data;
            if (w_pop && r_state == ADDR) reg_addr <= r_data;
            if (w_pop && r_state == DATA) reg_wdata <= r_data;
            if (r_state == RD_WAIT) r_rdata <= reg_rdata;
            // Response queue: first byte ACK/NAK, read adds the data byte twice (both served from r_rdata)
            if (w_next == RESP && r_state != RESP) begin
                r_rsp0 <= (r_state == EXEC || r_state == RD_WAIT) ? RSP_ACK : RSP_NAK;
                r_last <= r_state == RD_WAIT ? 2'd2 : 2'd0;
                r_idx  <= '0;
            end else if (wr_uart) begin
                r_idx <= r_idx + 2'd1;
            end
        end
    end
endmodule
